// File: rtl/lapido_mem_arbiter.sv
// rtl/lapido_mem_arbiter.sv - instruction/data arbiter for a shared single-port memory
module lapido_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  stall_pipeline,
   output logic                  timeout_err
);

   // Counter is sized to hold TIMEOUT; one extra bit on the increment avoids wrap in the compare.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW:0] TO_VAL = (CW + 1)'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, RESP} state_t;

   state_t                state_q, state_d;
   logic                  last_dm_q, last_dm_d;
   logic                  armed_q, armed_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  if_ack_q, if_ack_d;
   logic                  dm_ack_q, dm_ack_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW:0]           cnt_inc;
   logic                  grant_dm;

   assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);

   // On a tie the requester that did not win last time gets the memory.
   assign grant_dm = dm_req & (~if_req | ~last_dm_q);

   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign if_rdata       = if_rdata_q;
   assign dm_rdata       = dm_rdata_q;
   assign if_ack         = if_ack_q;
   assign dm_ack         = dm_ack_q;
   assign timeout_err    = timeout_err_q;
   assign stall_pipeline = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

   // Next-state and registered-output logic for the grant FSM.
   always_comb begin
      state_d       = state_q;
      last_dm_d     = last_dm_q;
      armed_d       = 1'b1;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      dm_rdata_d    = dm_rdata_q;
      if_ack_d      = 1'b0;
      dm_ack_d      = 1'b0;
      timeout_err_d = timeout_err_q;
      cnt_d         = cnt_q;

      case (state_q)
         IDLE: begin
            // armed_q holds off the first grant until one edge after reset release.
            if (armed_q && (if_req || dm_req)) begin
               mem_req_d = 1'b1;
               cnt_d     = '0;
               if (grant_dm) begin
                  state_d     = GNT_DM;
                  last_dm_d   = 1'b1;
                  mem_addr_d  = dm_addr;
                  mem_we_d    = dm_we;
                  mem_wdata_d = dm_wdata;
               end else begin
                  state_d    = GNT_IF;
                  last_dm_d  = 1'b0;
                  mem_addr_d = if_addr;
                  mem_we_d   = 1'b0;
               end
            end
         end
         GNT_IF, GNT_DM: begin
            // A completion in the same cycle as the timeout wins over the timeout.
            if (mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (state_q == GNT_DM) begin
                  dm_rdata_d = mem_rdata;
                  dm_ack_d   = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_ack_d   = 1'b1;
               end
            end else if (TIMEOUT != 0 && cnt_inc == TO_VAL) begin
               state_d       = RESP;
               mem_req_d     = 1'b0;
               mem_we_d      = 1'b0;
               timeout_err_d = 1'b1;
               if (state_q == GNT_DM) begin
                  dm_rdata_d = '0;
                  dm_ack_d   = 1'b1;
               end else begin
                  if_rdata_d = '0;
                  if_ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_inc[CW-1:0];
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with asynchronous active-low reset that aborts any transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         last_dm_q     <= 1'b0;
         armed_q       <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         if_ack_q      <= 1'b0;
         dm_ack_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         last_dm_q     <= last_dm_d;
         armed_q       <= armed_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         dm_rdata_q    <= dm_rdata_d;
         if_ack_q      <= if_ack_d;
         dm_ack_q      <= dm_ack_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
      end
   end

endmodule

// File: tb/tb_lapido_mem_arbiter.sv
// tb/tb_lapido_mem_arbiter.sv - directed self-checking bench for lapido_mem_arbiter
module tb_lapido_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_pipeline;
   logic        timeout_err;

   logic        resp_ack;
   logic        inj_ack;
   logic        mem_en;
   int          mem_lat;
   int          resp_cnt;
   int          n_tests;
   int          n_fail;

   lapido_mem_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_req        (if_req),
      .if_addr       (if_addr),
      .if_rdata      (if_rdata),
      .if_ack        (if_ack),
      .dm_req        (dm_req),
      .dm_we         (dm_we),
      .dm_addr       (dm_addr),
      .dm_wdata      (dm_wdata),
      .dm_rdata      (dm_rdata),
      .dm_ack        (dm_ack),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .stall_pipeline(stall_pipeline),
      .timeout_err   (timeout_err)
   );

   function automatic logic [31:0] model(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h8C22_0004;
      return {~a[15:0], a[15:0]};
   endfunction

   assign mem_rdata = resp_ack ? model(mem_addr) : 32'hDEAD_BEEF;
   assign mem_ack   = resp_ack | inj_ack;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: acks in the (mem_lat+1)-th cycle of mem_req.
   initial begin
      resp_ack = 1'b0;
      resp_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            resp_cnt = resp_cnt + 1;
            resp_ack = mem_en && (resp_cnt == mem_lat + 1);
         end else begin
            resp_cnt = 0;
            resp_ack = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_req(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (mem_req) break;
      end
      check(tag, 32'(mem_req), 32'd1);
   endtask

   task automatic wait_ack(input string tag, input logic exp_dm, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (if_ack || dm_ack) break;
      end
      check({tag, "_dm_ack"}, 32'(dm_ack), 32'(exp_dm));
      check({tag, "_if_ack"}, 32'(if_ack), 32'(!exp_dm));
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      inj_ack  = 1'b0;
      mem_en   = 1'b1;
      mem_lat  = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_if_ack", 32'(if_ack), 32'd0);
      check("rst_dm_ack", 32'(dm_ack), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);
      check("rst_stall", 32'(stall_pipeline), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Scenario 1: IF read, k=2, plus stray mem_ack in RESP/IDLE
      mem_lat = 2;
      if_addr = 32'h0000_0010;
      if_req  = 1'b1;
      #1;
      check("s1_stall_t", 32'(stall_pipeline), 32'd1);
      check("s1_req_t", 32'(mem_req), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("s1_mem_req", 32'(mem_req), 32'd1);
         check("s1_stall", 32'(stall_pipeline), 32'd1);
         check("s1_if_ack_low", 32'(if_ack), 32'd0);
         if (i == 1) begin
            check("s1_mem_addr", mem_addr, 32'h0000_0010);
            check("s1_mem_we", 32'(mem_we), 32'd0);
         end
      end
      @(negedge clk);
      check("s1_if_ack", 32'(if_ack), 32'd1);
      check("s1_if_rdata", if_rdata, 32'h8C22_0004);
      check("s1_stall_ack", 32'(stall_pipeline), 32'd0);
      check("s1_req_resp", 32'(mem_req), 32'd0);
      check("s1_dm_ack", 32'(dm_ack), 32'd0);
      if_req  = 1'b0;
      inj_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("s1_stray_if_ack", 32'(if_ack), 32'd0);
         check("s1_stray_mem_req", 32'(mem_req), 32'd0);
         check("s1_stray_if_rdata", if_rdata, 32'h8C22_0004);
         check("s1_stray_dm_rdata", dm_rdata, 32'd0);
      end
      inj_ack = 1'b0;
      @(negedge clk);

      // Scenario 2: simultaneous IF and DM, DM write wins
      mem_lat  = 1;
      if_addr  = 32'h0000_0020;
      dm_we    = 1'b1;
      dm_addr  = 32'h0000_0100;
      dm_wdata = 32'hCAFE_F00D;
      if_req   = 1'b1;
      dm_req   = 1'b1;
      @(negedge clk);
      check("s2_mem_req", 32'(mem_req), 32'd1);
      check("s2_mem_we", 32'(mem_we), 32'd1);
      check("s2_mem_addr", mem_addr, 32'h0000_0100);
      check("s2_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      @(negedge clk);
      @(negedge clk);
      check("s2_dm_ack", 32'(dm_ack), 32'd1);
      check("s2_if_ack_low", 32'(if_ack), 32'd0);
      check("s2_dm_rdata", dm_rdata, model(32'h0000_0100));
      dm_req = 1'b0;
      dm_we  = 1'b0;
      @(negedge clk);
      check("s2_dm_ack_single", 32'(dm_ack), 32'd0);
      check("s2_idle_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("s2_if_gnt", 32'(mem_req), 32'd1);
      check("s2_if_addr", mem_addr, 32'h0000_0020);
      check("s2_if_we", 32'(mem_we), 32'd0);
      wait_ack("s2_if", 1'b0, 5);
      check("s2_if_rdata", if_rdata, model(32'h0000_0020));
      if_req = 1'b0;
      @(negedge clk);
      check("s2_if_ack_single", 32'(if_ack), 32'd0);
      check("s2_dm_ack_none", 32'(dm_ack), 32'd0);

      // Scenario 3: both held, six alternating grants
      mem_lat = 0;
      dm_addr = 32'h0000_0200;
      if_addr = 32'h0000_0300;
      dm_req  = 1'b1;
      if_req  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_req("s3_req", 6);
         check("s3_gnt_addr", mem_addr, (i % 2 == 0) ? 32'h0000_0200 : 32'h0000_0300);
         wait_ack("s3", (i % 2 == 0), 4);
         if (i == 5) begin
            if_req = 1'b0;
            dm_req = 1'b0;
         end
         @(negedge clk);
         check("s3_ack_single", 32'(if_ack | dm_ack), 32'd0);
      end
      @(negedge clk);
      check("s3_idle", 32'(mem_req), 32'd0);

      // Scenario 4a: mem_ack on the cycle the counter reaches TIMEOUT
      mem_lat = 3;
      dm_addr = 32'h0000_0440;
      dm_req  = 1'b1;
      wait_req("s4a_req", 4);
      wait_ack("s4a", 1'b1, 6);
      check("s4a_no_err", 32'(timeout_err), 32'd0);
      check("s4a_dm_rdata", dm_rdata, model(32'h0000_0440));
      dm_req = 1'b0;
      repeat (2) @(negedge clk);

      // Scenario 4b: mem_ack never arrives
      mem_en  = 1'b0;
      dm_addr = 32'h0000_0400;
      dm_req  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("s4b_mem_req", 32'(mem_req), 32'd1);
         check("s4b_err_low", 32'(timeout_err), 32'd0);
      end
      @(negedge clk);
      check("s4b_req_drop", 32'(mem_req), 32'd0);
      check("s4b_dm_ack", 32'(dm_ack), 32'd1);
      check("s4b_dm_rdata", dm_rdata, 32'd0);
      check("s4b_err", 32'(timeout_err), 32'd1);
      dm_req = 1'b0;
      repeat (10) @(negedge clk);
      check("s4b_err_sticky", 32'(timeout_err), 32'd1);
      check("s4b_dm_ack_gone", 32'(dm_ack), 32'd0);
      mem_en = 1'b1;

      // Scenario 5: reset in GNT_DM, then regrant with a tie
      mem_lat  = 3;
      dm_we    = 1'b1;
      dm_addr  = 32'h0000_0500;
      dm_wdata = 32'h1234_5678;
      dm_req   = 1'b1;
      @(negedge clk);
      check("s5_gnt_dm", 32'(mem_req), 32'd1);
      check("s5_gnt_we", 32'(mem_we), 32'd1);
      rst = 1'b0;
      #1;
      check("s5_rst_req", 32'(mem_req), 32'd0);
      check("s5_rst_we", 32'(mem_we), 32'd0);
      check("s5_rst_err", 32'(timeout_err), 32'd0);
      check("s5_rst_addr", mem_addr, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("s5_rst_no_ack", 32'(dm_ack), 32'd0);
         check("s5_rst_req_low", 32'(mem_req), 32'd0);
      end
      if_addr = 32'h0000_0600;
      if_req  = 1'b1;
      rst     = 1'b1;
      #1;
      check("s5_rel_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("s5_first_edge", 32'(mem_req), 32'd0);
      check("s5_first_edge_ack", 32'(dm_ack), 32'd0);
      @(negedge clk);
      check("s5_regrant", 32'(mem_req), 32'd1);
      check("s5_regrant_addr", mem_addr, 32'h0000_0500);
      check("s5_regrant_we", 32'(mem_we), 32'd1);
      check("s5_regrant_wdata", mem_wdata, 32'h1234_5678);
      wait_ack("s5_dm", 1'b1, 6);
      check("s5_dm_rdata", dm_rdata, model(32'h0000_0500));
      dm_req = 1'b0;
      dm_we  = 1'b0;
      wait_ack("s5_if", 1'b0, 8);
      check("s5_if_rdata", if_rdata, model(32'h0000_0600));
      if_req = 1'b0;
      @(negedge clk);
      check("s5_if_ack_single", 32'(if_ack), 32'd0);
      check("s5_final_err", 32'(timeout_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
